// File: rtl/unstripe_pkg.sv
// Shared types and constants for the two-lane unstriping stage.
package unstripe_pkg;

    localparam int DATA_W    = 32;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        SEL0 = 1'b0,
        SEL1 = 1'b1
    } sel_t;

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane FIFO; writes while full are dropped, pops only when non-empty.
import unstripe_pkg::*;

module lane_fifo #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_2f) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/unstripe.sv
// Reassembles a two-lane striped stream in strict lane0/lane1 order.
// Optional sticky overflow flag: define UNSTRIPE_OVF_ERR_EN.
import unstripe_pkg::*;

module unstripe #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AFULL = DEPTH - 1
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane0,
    input  logic [DATA_W-1:0] lane1,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              ready,
    output logic [DATA_W-1:0] dataOut,
    output logic              validOut,
    output logic              pause,
    output logic              err_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic [CW-1:0]     count0;
    logic [CW-1:0]     count1;
    logic              full0;
    logic              full1;
    logic              empty0;
    logic              empty1;
    logic              pop0;
    logic              pop1;

    sel_t              sel;
    sel_t              sel_nxt;
    logic              load;
    logic              sel_empty;
    logic [DATA_W-1:0] head;

    lane_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid0),
        .pop    (pop0),
        .din    (lane0),
        .dout   (dout0),
        .count  (count0),
        .full   (full0),
        .empty  (empty0)
    );

    lane_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid1),
        .pop    (pop1),
        .din    (lane1),
        .dout   (dout1),
        .count  (count1),
        .full   (full1),
        .empty  (empty1)
    );

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel <= SEL0;
        end else begin
            sel <= sel_nxt;
        end
    end

    // An empty selected lane stalls the selector; the other lane waits.
    always_comb begin
        sel_nxt   = sel;
        pop0      = 1'b0;
        pop1      = 1'b0;
        load      = !validOut || ready;
        head      = dout0;
        sel_empty = empty0;
        unique case (sel)
            SEL0: begin
                head      = dout0;
                sel_empty = empty0;
                if (load && !empty0) begin
                    pop0    = 1'b1;
                    sel_nxt = SEL1;
                end
            end
            SEL1: begin
                head      = dout1;
                sel_empty = empty1;
                if (load && !empty1) begin
                    pop1    = 1'b1;
                    sel_nxt = SEL0;
                end
            end
            default: sel_nxt = SEL0;
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            dataOut  <= '0;
            validOut <= 1'b0;
        end else if (load) begin
            if (!sel_empty) begin
                dataOut  <= head;
                validOut <= 1'b1;
            end else begin
                validOut <= 1'b0;
            end
        end
    end

    assign pause = (count0 >= CW'(AFULL)) || (count1 >= CW'(AFULL));

`ifdef UNSTRIPE_OVF_ERR_EN
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            err_ovf <= 1'b0;
        end else if ((valid0 && full0) || (valid1 && full1)) begin
            err_ovf <= 1'b1;
        end
    end
`else
    assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_unstripe.sv
// Self-checking bench for unstripe against a queue-based reference model.
module tb_unstripe;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic [31:0] lane0;
    logic [31:0] lane1;
    logic        valid0;
    logic        valid1;
    logic        ready;
    logic [31:0] dataOut;
    logic        validOut;
    logic        pause;
    logic        err_ovf;

    int compared = 0;
    int mism     = 0;

    // Reference state: one queue per lane plus the expected output register.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          want_lane;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_err;

    unstripe #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane0    (lane0),
        .lane1    (lane1),
        .valid0   (valid0),
        .valid1   (valid1),
        .ready    (ready),
        .dataOut  (dataOut),
        .validOut (validOut),
        .pause    (pause),
        .err_ovf  (err_ovf)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v0,
                              input logic [31:0] d0, input logic v1,
                              input logic [31:0] d1, input logic rdy);
        bit f0;
        bit f1;
        if (rst) begin
            q0.delete();
            q1.delete();
            want_lane = 0;
            m_data    = '0;
            m_valid   = 1'b0;
            m_err     = 1'b0;
            return;
        end
        f0 = (q0.size() == DEPTH);
        f1 = (q1.size() == DEPTH);
        if (!m_valid || rdy) begin
            if (want_lane == 0 && q0.size() > 0) begin
                m_data = q0.pop_front();
                m_valid = 1'b1;
                want_lane = 1;
            end else if (want_lane == 1 && q1.size() > 0) begin
                m_data = q1.pop_front();
                m_valid = 1'b1;
                want_lane = 0;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (v0) begin
            if (f0) m_err = 1'b1;
            else q0.push_back(d0);
        end
        if (v1) begin
            if (f1) m_err = 1'b1;
            else q1.push_back(d1);
        end
    endtask

    task automatic step(input string tag, input logic rst,
                        input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1,
                        input logic rdy);
        logic exp_err;
        logic exp_pause;
        reset  = rst;
        valid0 = v0;
        lane0  = d0;
        valid1 = v1;
        lane1  = d1;
        ready  = rdy;
        @(posedge clk_2f);
        model_edge(rst, v0, d0, v1, d1, rdy);
        #1;
`ifdef UNSTRIPE_OVF_ERR_EN
        exp_err = m_err;
`else
        exp_err = 1'b0;
`endif
        exp_pause = (q0.size() >= AFULL) || (q1.size() >= AFULL);
        chk({tag, ".data"}, dataOut, m_data);
        chk({tag, ".valid"}, {31'b0, validOut}, {31'b0, m_valid});
        chk({tag, ".pause"}, {31'b0, pause}, {31'b0, exp_pause});
        chk({tag, ".err"}, {31'b0, err_ovf}, {31'b0, exp_err});
    endtask

    task automatic idle(input string tag, input logic rdy);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        lane0 = '0;
        lane1 = '0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        ready = 1'b0;
        want_lane = 0;
        m_data = '0;
        m_valid = 1'b0;
        m_err = 1'b0;

        // Reset state, inputs presented during reset must be ignored.
        step("rst", 1'b1, 1'b1, 32'hDEAD0000, 1'b1, 32'hDEAD0001, 1'b1);
        chk("rst_data", dataOut, 32'h0);
        chk("rst_valid", {31'b0, validOut}, 32'h0);
        step("rst2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // A0 on lane0, then B1 on lane1.
        step("a0", 1'b0, 1'b1, 32'hA0A0A0A0, 1'b0, 32'h0, 1'b1);
        step("b1", 1'b0, 1'b0, 32'h0, 1'b1, 32'hB1B1B1B1, 1'b1);
        chk("a0_out", dataOut, 32'hA0A0A0A0);
        idle("b1o", 1'b1);
        chk("b1_out", dataOut, 32'hB1B1B1B1);
        idle("drain", 1'b1);
        chk("drain_valid", {31'b0, validOut}, 32'h0);

        // Lane1 alone must wait for lane0.
        step("l1", 1'b0, 1'b0, 32'h0, 1'b1, 32'h11, 1'b1);
        idle("l1w", 1'b1);
        idle("l1w2", 1'b1);
        chk("l1_wait", {31'b0, validOut}, 32'h0);
        step("l0", 1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 1'b1);
        idle("o22", 1'b1);
        chk("o22", dataOut, 32'h22);
        idle("o11", 1'b1);
        chk("o11", dataOut, 32'h11);
        idle("o11d", 1'b1);

        // Fill both lanes with ready low and overrun lane0.
        for (int i = 0; i < 4; i++) begin
            step("fill", 1'b0, 1'b1, 32'h100 + i, 1'b1, 32'h200 + i, 1'b0);
        end
        step("ovf0", 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
        step("ovf1", 1'b0, 1'b1, 32'h105, 1'b0, 32'h0, 1'b0);
        chk("full_pause", {31'b0, pause}, 32'h1);
        for (int i = 0; i < 10; i++) idle("unfill", 1'b1);
        step("rstf", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Eight words with ready toggling.
        for (int i = 0; i < 8; i++) begin
            step("tog", 1'b0, i % 2 == 0, i, i % 2 == 1, i, i % 3 != 1);
        end
        for (int i = 0; i < 12; i++) idle("togd", i % 2 == 0);

        // Reset with words buffered, then a fresh stream.
        step("buf0", 1'b0, 1'b1, 32'h31, 1'b1, 32'h32, 1'b0);
        step("buf1", 1'b0, 1'b1, 32'h33, 1'b1, 32'h34, 1'b0);
        step("midrst", 1'b1, 1'b1, 32'h35, 1'b0, 32'h0, 1'b1);
        chk("midrst_valid", {31'b0, validOut}, 32'h0);
        step("new0", 1'b0, 1'b1, 32'h41, 1'b0, 32'h0, 1'b1);
        step("new1", 1'b0, 1'b0, 32'h0, 1'b1, 32'h42, 1'b1);
        chk("new_first", dataOut, 32'h41);
        idle("new2", 1'b1);
        chk("new_second", dataOut, 32'h42);

        // Sustained alternating one word per cycle.
        for (int i = 0; i < 16; i++) begin
            step("sus", 1'b0, i % 2 == 0, 32'h500 + i, i % 2 == 1,
                 32'h500 + i, 1'b1);
        end
        idle("susd", 1'b1);
        idle("susd2", 1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 63) == 0,
                 $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
